// File: rtl/lstm_pkg.sv
// Shared sizing helpers and state encoding for the LSTM sequencer.
package lstm_pkg;

    function automatic int bitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        NRST,
        WAIT_IN,
        PULSE,
        WAIT_L,
        EN_P,
        WAIT_P,
        EMIT
    } seqState_t;

endpackage

// File: rtl/seq_edge_det.sv
// Rising-edge detector against the level seen on the previous clock.
module seq_edge_det (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clock) begin
        if (reset) prev <= 1'b0;
        else       prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/lstm_seq_sequencer.sv
// Steps an LSTM network over variable-length sample sequences:
// network reset, per-step handshakes, result emission and watchdog.
module lstm_seq_sequencer
    import lstm_pkg::*;
#(
    parameter int INPUT_SZ    = 2,
    parameter int QN          = 6,
    parameter int QM          = 11,
    parameter int MAX_SEQ_LEN = 8,
    parameter int NET_RST_CYC = 4,
    parameter int WDOG_CYC    = 4096,
    parameter int BITWIDTH    = bitwidth(QN, QM),
    parameter int LEN_W       = log2(MAX_SEQ_LEN) + 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         seq_start,
    input  logic [LEN_W-1:0]             seq_len,
    input  logic                         last_only,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INPUT_SZ*BITWIDTH-1:0] in_data,
    output logic [INPUT_SZ*BITWIDTH-1:0] net_input,
    output logic                         net_reset,
    output logic                         net_new_sample,
    input  logic                         net_data_ready,
    output logic                         net_en_percep,
    input  logic                         net_ready_p,
    input  logic [BITWIDTH-1:0]          net_output,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BITWIDTH-1:0]          out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic                         wdog_err
);

    localparam int RST_W  = log2(NET_RST_CYC) + 1;
    localparam int WDOG_W = log2(WDOG_CYC) + 1;

    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_SEQ_LEN);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(NET_RST_CYC - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

    seqState_t         state;
    seqState_t         stateNext;
    logic [LEN_W-1:0]  seqLen;
    logic [LEN_W-1:0]  stepCnt;
    logic [LEN_W-1:0]  clampLen;
    logic              lastOnly;
    logic [RST_W-1:0]  rstCnt;
    logic [WDOG_W-1:0] wdogCnt;
    logic              rstPulse;
    logic              readyRise;
    logic              readyPRise;
    logic              startAcc;
    logic              abortHit;
    logic              inFire;
    logic              stepDone;
    logic              finalStep;
    logic              waiting;
    logic              timeout;

    seq_edge_det uReadyEdge (
        .clock (clock),
        .reset (reset),
        .level (net_data_ready),
        .rise  (readyRise)
    );

    seq_edge_det uReadyPEdge (
        .clock (clock),
        .reset (reset),
        .level (net_ready_p),
        .rise  (readyPRise)
    );

    assign startAcc  = (state == IDLE) && seq_start;
    assign abortHit  = (state != IDLE) && abort;
    assign inFire    = (state == WAIT_IN) && in_valid && !abort;
    assign stepDone  = (state == WAIT_P) && readyPRise && !abort;
    assign finalStep = (stepCnt + LEN_W'(1)) == seqLen;
    assign waiting   = (state == WAIT_L) || (state == WAIT_P);

    // an edge arriving on the last watchdog cycle still counts
    assign timeout = (wdogCnt == WDOG_LAST) && !abort
                   && (((state == WAIT_L) && !readyRise)
                    || ((state == WAIT_P) && !readyPRise));

    always_comb begin
        clampLen = seq_len;
        if (seq_len == '0)          clampLen = LEN_W'(1);
        else if (seq_len > MAX_LEN) clampLen = MAX_LEN;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (seq_start) stateNext = NRST;
            NRST:    if (rstCnt == RST_LAST) stateNext = WAIT_IN;
            WAIT_IN: if (in_valid) stateNext = PULSE;
            PULSE:   stateNext = WAIT_L;
            WAIT_L: begin
                if (readyRise)    stateNext = EN_P;
                else if (timeout) stateNext = IDLE;
            end
            EN_P:    stateNext = WAIT_P;
            WAIT_P: begin
                if (readyPRise) begin
                    if (lastOnly && !finalStep) stateNext = WAIT_IN;
                    else                        stateNext = EMIT;
                end else if (timeout) begin
                    stateNext = IDLE;
                end
            end
            EMIT: begin
                if (out_ready) stateNext = out_last ? IDLE : WAIT_IN;
            end
            default: stateNext = IDLE;
        endcase
        if (abortHit) stateNext = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            seqLen    <= '0;
            stepCnt   <= '0;
            lastOnly  <= 1'b0;
            rstCnt    <= '0;
            wdogCnt   <= '0;
            rstPulse  <= 1'b1;
            wdog_err  <= 1'b0;
            net_input <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state    <= stateNext;
            rstPulse <= abortHit | timeout;
            rstCnt   <= (state == NRST) ? rstCnt + RST_W'(1) : '0;
            wdogCnt  <= (waiting && stateNext == state)
                      ? wdogCnt + WDOG_W'(1) : '0;
            if (startAcc) begin
                seqLen   <= clampLen;
                lastOnly <= last_only;
                stepCnt  <= '0;
                wdog_err <= 1'b0;
                out_last <= 1'b0;
            end
            if (inFire) net_input <= in_data;
            if (stepDone) begin
                stepCnt  <= stepCnt + LEN_W'(1);
                out_data <= net_output;
                out_last <= finalStep;
            end
            if (timeout) wdog_err <= 1'b1;
        end
    end

    assign in_ready       = (state == WAIT_IN);
    assign net_new_sample = (state == PULSE);
    assign net_en_percep  = (state == EN_P) || (state == WAIT_P);
    assign out_valid      = (state == EMIT);
    assign busy           = (state != IDLE);
    assign net_reset      = (state == NRST) || rstPulse;

endmodule

// File: tb/tb_lstm_seq_sequencer.sv
// Bench for lstm_seq_sequencer: network model, output scoreboard,
// table of sequence runs and hand-written corner-case sequences.
module tb_lstm_seq_sequencer;

    localparam int BW       = 18;
    localparam int IW       = 2 * BW;
    localparam int LW       = 4;
    localparam int DR_DELAY = 20;
    localparam int RP_DELAY = 5;

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        int len;
        bit lo;
        int eff;
    } row_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          seq_start = 1'b0;
    logic [LW-1:0] seq_len = '0;
    logic          last_only = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic [IW-1:0] net_input;
    logic          net_reset;
    logic          net_new_sample;
    logic          dataReady = 1'b0;
    logic          net_en_percep;
    logic          readyP = 1'b0;
    logic [BW-1:0] netOutput = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          wdog_err;

    int errors = 0;
    int checks = 0;
    exp_t expQ[$];
    row_t rows[5];
    logic [BW-1:0] netOut[8];
    bit neverReady = 1'b0;

    lstm_seq_sequencer #(.WDOG_CYC(64)) dut (
        .clock          (clock),
        .reset          (reset),
        .seq_start      (seq_start),
        .seq_len        (seq_len),
        .last_only      (last_only),
        .abort          (abort),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .net_input      (net_input),
        .net_reset      (net_reset),
        .net_new_sample (net_new_sample),
        .net_data_ready (dataReady),
        .net_en_percep  (net_en_percep),
        .net_ready_p    (readyP),
        .net_output     (netOutput),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .wdog_err       (wdog_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // network model: levels rise after fixed delays, cleared by net_reset
    int drCnt = 0;
    int rpCnt = RP_DELAY;
    int stepIdx = 0;
    always begin
        @(posedge clock);
        #1;
        if (reset || net_reset) begin
            dataReady = 1'b0;
            readyP = 1'b0;
            drCnt = 0;
            rpCnt = RP_DELAY;
            stepIdx = 0;
        end else begin
            if (net_new_sample) begin
                dataReady = 1'b0;
                drCnt = DR_DELAY;
            end else if (drCnt > 0) begin
                drCnt--;
                if (drCnt == 0 && !neverReady) dataReady = 1'b1;
            end
            if (!net_en_percep) begin
                readyP = 1'b0;
                rpCnt = RP_DELAY;
            end else if (!readyP && rpCnt > 0) begin
                rpCnt--;
                if (rpCnt == 0) begin
                    readyP = 1'b1;
                    netOutput = netOut[stepIdx % 8];
                    stepIdx++;
                end
            end
        end
    end

    // monitors: pulse widths, reset run length, emit latency, scoreboard
    int cyc = 0;
    int nsRun = 0, nsPulses = 0, nsBad = 0;
    int rstRun = 0, lastRstRun = 0;
    int rpRiseCyc = 0;
    logic rpPrev = 1'b0, ovPrev = 1'b0;
    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (!reset) begin
            if (net_new_sample) nsRun++;
            else if (nsRun > 0) begin
                nsPulses++;
                if (nsRun != 1) nsBad++;
                nsRun = 0;
            end
            if (net_reset) rstRun++;
            else if (rstRun > 0) begin
                lastRstRun = rstRun;
                rstRun = 0;
            end
            if (readyP && !rpPrev) rpRiseCyc = cyc;
            if (out_valid && !ovPrev)
                check("emit_latency", 64'(cyc - rpRiseCyc), 1);
            if (out_valid && out_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none",
                             out_data);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checks++;
                    if (out_data !== e.data || out_last !== e.last) begin
                        errors++;
                        $display("FAIL out: got %0h/%0b expected %0h/%0b",
                                 out_data, out_last, e.data, e.last);
                    end
                end
            end
        end
        rpPrev = readyP;
        ovPrev = out_valid;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic startSeq(input int len, input bit lo);
        seq_len = LW'(len);
        last_only = lo;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        check("start_busy", busy, 1);
        check("start_wdog_clr", wdog_err, 0);
        check("start_net_reset", net_reset, 1);
    endtask

    task automatic feed(input logic [IW-1:0] d);
        int n = 0;
        while (!in_ready && n < 2000) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        if (in_ready) begin
            in_valid = 1'b1;
            in_data = d;
            tick();
            in_valid = 1'b0;
            check("new_sample_lat", net_new_sample, 1);
            check("net_input", net_input, d);
        end
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((busy || expQ.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check(name, (busy || expQ.size() != 0) ? 0 : 1, 1);
    endtask

    function automatic logic [IW-1:0] rndSample();
        return IW'({$urandom(), $urandom()});
    endfunction

    task automatic runSeq(input int len, input bit lo, input int eff);
        int base = nsPulses;
        int badBase = nsBad;
        for (int i = 0; i < eff; i++) begin
            if (!lo || i == eff - 1) expQ.push_back('{netOut[i], i == eff - 1});
        end
        lastRstRun = 0;
        startSeq(len, lo);
        for (int i = 0; i < eff; i++) feed(rndSample());
        waitIdle("seq_done");
        check("nrst_cycles", 64'(lastRstRun), 4);
        check("pulse_count", 64'(nsPulses - base), 64'(eff));
        check("pulse_width", 64'(nsBad - badBase), 0);
    endtask

    initial begin
        int n;
        int bad;
        netOut[0] = 18'h00800;
        netOut[1] = 18'h00C00;
        netOut[2] = 18'h3F800;
        netOut[3] = 18'h01234;
        netOut[4] = 18'h2ABCD;
        netOut[5] = 18'h00001;
        netOut[6] = 18'h3FFFF;
        netOut[7] = 18'h15A5A;
        rows[0] = '{0, 1'b0, 1};
        rows[1] = '{3, 1'b0, 3};
        rows[2] = '{8, 1'b1, 8};
        rows[3] = '{12, 1'b0, 8};
        rows[4] = '{3, 1'b1, 3};

        repeat (3) tick();
        check("rst_net_reset", net_reset, 1);
        check("rst_outs", {busy, in_ready, out_valid, net_new_sample,
                           net_en_percep, wdog_err, out_last}, 0);
        check("rst_data", {out_data, net_input}, 0);
        reset = 1'b0;
        repeat (2) tick();
        check("idle_net_reset", net_reset, 0);

        // output stall in EMIT
        out_ready = 1'b0;
        expQ.push_back('{netOut[0], 1'b0});
        expQ.push_back('{netOut[1], 1'b1});
        startSeq(2, 1'b0);
        feed(rndSample());
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check("stall_valid", out_valid, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || out_data !== netOut[0] || in_ready || net_new_sample)
                bad++;
        end
        check("stall_stable", 64'(bad), 0);
        check("stall_pulses", 64'(nsPulses), 1);
        out_ready = 1'b1;
        feed(rndSample());
        waitIdle("stall_done");

        // watchdog on a network that never raises dataReady
        neverReady = 1'b1;
        startSeq(1, 1'b0);
        feed(rndSample());
        n = 0;
        while (n < 200) begin
            tick();
            if (wdog_err) break;
            n++;
        end
        check("wdog_cycles", 64'(n), 64);
        check("wdog_busy", busy, 0);
        check("wdog_net_reset", net_reset, 1);
        tick();
        check("wdog_sticky", wdog_err, 1);
        check("wdog_rst_1cyc", net_reset, 0);
        neverReady = 1'b0;
        runSeq(1, 1'b0, 1);

        // reset while waiting on dataReadyP
        startSeq(2, 1'b0);
        feed(rndSample());
        n = 0;
        while (!net_en_percep && n < 200) begin
            tick();
            n++;
        end
        tick();
        check("pre_reset_waitp", net_en_percep, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_net_reset", net_reset, 1);
        check("mid_rst_outs", {busy, in_ready, out_valid, net_new_sample,
                               net_en_percep, wdog_err, out_last}, 0);
        check("mid_rst_data", {out_data, net_input}, 0);
        reset = 1'b0;
        repeat (3) tick();

        // abort coinciding with the step-2 dataReadyP edge
        expQ.push_back('{netOut[0], 1'b0});
        startSeq(3, 1'b0);
        feed(rndSample());
        feed(rndSample());
        n = 0;
        while (!readyP && n < 200) begin
            tick();
            n++;
        end
        check("abort_edge_seen", readyP, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_net_reset", net_reset, 1);
        check("abort_quiet", {out_valid, net_en_percep, net_new_sample}, 0);
        tick();
        check("abort_rst_1cyc", net_reset, 0);
        repeat (5) tick();
        check("abort_queue", 64'(expQ.size()), 0);

        for (int r = 0; r < 5; r++) runSeq(rows[r].len, rows[r].lo, rows[r].eff);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
